// File: rtl/collect_pkg.sv
// Shared bag codes, FSM/step encodings and reply mapping for the collect link master.
package collect_pkg;

  localparam logic [3:0] BAG_DLINK  = 4'b1000;
  localparam logic [3:0] BAG_DTYPE  = 4'b1001;
  localparam logic [3:0] BAG_DTEMP  = 4'b1010;
  localparam logic [3:0] BAG_DATA0  = 4'b1101;
  localparam logic [3:0] BAG_DATA1  = 4'b1110;

  localparam logic [3:0] BAG_DIDX   = 4'b0101;
  localparam logic [3:0] BAG_DPARAM = 4'b0110;
  localparam logic [3:0] BAG_DDIDX  = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_CHECK = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    STEP_LINK  = 3'd0,
    STEP_TYPE  = 3'd1,
    STEP_TEMP  = 3'd2,
    STEP_DATA0 = 3'd3,
    STEP_DATA1 = 3'd4
  } step_t;

  function automatic logic [3:0] expected_reply(input logic [3:0] cmd);
    case (cmd)
      BAG_DLINK: return BAG_DIDX;
      BAG_DTYPE: return BAG_DPARAM;
      default:   return BAG_DDIDX;
    endcase
  endfunction

  function automatic logic [3:0] step_cmd(input step_t s);
    case (s)
      STEP_LINK:  return BAG_DLINK;
      STEP_TYPE:  return BAG_DTYPE;
      STEP_TEMP:  return BAG_DTEMP;
      STEP_DATA0: return BAG_DATA0;
      default:    return BAG_DATA1;
    endcase
  endfunction

endpackage

// File: rtl/collect_wdt.sv
// Loadable down-counter shared by the reply watchdog and the inter-command gap.
// done is high while enabled and the count has reached zero.
module collect_wdt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        done
);

  logic [15:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 16'd0;
    end else if (clr) begin
      cnt_reg <= 16'd0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != 16'd0)) begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  assign done = en && (cnt_reg == 16'd0);

endmodule

// File: rtl/collect_master.sv
// Command sequencer for the collect link: LINK, TYPE, [TEMP], then DATA0/DATA1 poll.
// Define COLLECT_MASTER_TEMP_EN to include the DTEMP step in the sequence.
module collect_master
  import collect_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd2000,
  parameter int          RETRY   = 3,
  parameter logic [7:0]  GAP     = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        fs_send,
  output logic [3:0]  send_btype,
  input  logic        fd_send,
  input  logic        fs_read,
  input  logic [3:0]  read_btype,
  output logic        fd_read,
  output logic        link,
  output logic        err,
  output logic [3:0]  err_code,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0]  RETRY_MAX = 8'(RETRY);
  // Loading N-1 makes done appear in the N-th enabled cycle.
  localparam logic [15:0] WAIT_LOAD = TIMEOUT - 16'd1;
  localparam logic [15:0] GAP_LOAD  = (GAP == 8'd0) ? 16'd0 : ({8'd0, GAP} - 16'd1);

  state_t      state_reg, state_next;
  step_t       step_reg, step_next;
  logic [7:0]  retry_reg, retry_next;
  logic [3:0]  rtype_reg, rtype_next;
  logic        link_reg, link_next;
  logic        err_reg, err_next;
  logic [3:0]  err_code_reg, err_code_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;
  logic        fs_send_reg;
  logic [3:0]  send_btype_reg;
  logic        fd_read_reg;

  logic        wdt_load;
  logic [15:0] wdt_val;
  logic        wdt_en;
  logic        wdt_clr;
  logic        wdt_done;
  logic        fail;
  logic [3:0]  cur_cmd;
  logic        is_data;

  function automatic step_t step_after(input step_t s);
    case (s)
      STEP_LINK:  return STEP_TYPE;
`ifdef COLLECT_MASTER_TEMP_EN
      STEP_TYPE:  return STEP_TEMP;
      STEP_TEMP:  return STEP_DATA0;
`else
      STEP_TYPE:  return STEP_DATA0;
`endif
      STEP_DATA0: return STEP_DATA1;
      default:    return STEP_DATA0;
    endcase
  endfunction

  assign cur_cmd = step_cmd(step_reg);
  assign is_data = (step_reg == STEP_DATA0) || (step_reg == STEP_DATA1);
  assign wdt_en  = (state_reg == ST_WAIT) || (state_reg == ST_GAP);
  assign wdt_clr = (state_reg == ST_IDLE);

  collect_wdt u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clr      (wdt_clr),
    .load     (wdt_load),
    .load_val (wdt_val),
    .en       (wdt_en),
    .done     (wdt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      step_reg       <= STEP_LINK;
      retry_reg      <= 8'd0;
      rtype_reg      <= 4'd0;
      link_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= 4'd0;
      frame_cnt_reg  <= 16'd0;
      fs_send_reg    <= 1'b0;
      send_btype_reg <= 4'd0;
      fd_read_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      step_reg       <= step_next;
      retry_reg      <= retry_next;
      rtype_reg      <= rtype_next;
      link_reg       <= link_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
      frame_cnt_reg  <= frame_cnt_next;
      fs_send_reg    <= (state_next == ST_SEND);
      send_btype_reg <= (state_next == ST_SEND) ? step_cmd(step_next) : 4'd0;
      fd_read_reg    <= (state_next == ST_ACK);
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    retry_next     = retry_reg;
    rtype_next     = rtype_reg;
    link_next      = link_reg;
    err_next       = err_reg;
    err_code_next  = err_code_reg;
    frame_cnt_next = frame_cnt_reg;
    wdt_load       = 1'b0;
    wdt_val        = 16'd0;
    fail           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SEND;
          step_next      = STEP_LINK;
          retry_next     = 8'd0;
          link_next      = 1'b0;
          err_next       = 1'b0;
          err_code_next  = 4'd0;
          frame_cnt_next = 16'd0;
        end
      end
      ST_SEND: begin
        if (fd_send) begin
          state_next = ST_WAIT;
          wdt_load   = 1'b1;
          wdt_val    = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        // A reply arriving in the expiry cycle takes priority over the timeout.
        if (fs_read) begin
          state_next = ST_ACK;
          rtype_next = read_btype;
        end else if (wdt_done) begin
          fail = 1'b1;
        end
      end
      ST_ACK: begin
        if (!fs_read) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rtype_reg == expected_reply(cur_cmd)) begin
          retry_next = 8'd0;
          if (step_reg == STEP_LINK) begin
            link_next = 1'b1;
          end
          if (is_data) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end
          if (is_data && stop) begin
            state_next = ST_IDLE;
            link_next  = 1'b0;
          end else begin
            state_next = ST_GAP;
            step_next  = step_after(step_reg);
            wdt_load   = 1'b1;
            wdt_val    = GAP_LOAD;
          end
        end else begin
          fail = 1'b1;
        end
      end
      ST_GAP: begin
        if (wdt_done) begin
          state_next = ST_SEND;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_reg == RETRY_MAX) begin
        state_next    = ST_IDLE;
        err_next      = 1'b1;
        err_code_next = cur_cmd;
        link_next     = 1'b0;
      end else begin
        state_next = ST_SEND;
        retry_next = retry_reg + 8'd1;
      end
    end
  end

  assign fs_send    = fs_send_reg;
  assign send_btype = send_btype_reg;
  assign fd_read    = fd_read_reg;
  assign link       = link_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule
